hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the in-order RV32 pipeline. It sits beside `control` and tracks the destination register of every in-flight instruction between X and the last pipeline stage. From that state it produces registered bypass selects for the X-stage operand muxes, a load-use stall, and a multi-cycle branch squash window. `STAGES`, `LOAD_GAP` and `FLUSH_DEPTH` generalise the fixed 3-stage bypass logic to deeper pipelines and longer fetch latency.

---
 rtl/hazard_unit.sv | 103 ++++++++++
 tb/tb_hazard_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
`timescale 1ns/1ps
// Hazard/forwarding controller: tracks in-flight rd from X to the last stage; fwd_* and kill_id registered (1 cycle).
// stall is combinational (load-use); br_taken overrides stall and opens a FLUSH_DEPTH-cycle decode squash window.
module hazard_unit #(
   parameter int ADDR_W      = 5,
   parameter int STAGES      = 2,
   parameter int LOAD_GAP    = 1,
   parameter int FLUSH_DEPTH = 1,
   parameter int CNT_W       = 16,
   localparam int FW         = (STAGES > 2) ? $clog2(STAGES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs1,
   input  logic [ADDR_W-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic              br_taken,
   output logic              stall,
   output logic              kill_id,
   output logic [FW-1:0]     fwd_a,
   output logic [FW-1:0]     fwd_b,
   output logic [CNT_W-1:0]  stall_count
);

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] rd;
      logic              we;
      logic              ld;
   } ent_t;

   ent_t             r_e [1:STAGES];
   logic [2:0]       r_fc;
   logic [FW-1:0]    r_fwd_a;
   logic [FW-1:0]    r_fwd_b;
   logic [CNT_W-1:0] r_cnt;

   logic             w_kill;
   logic             w_hz;
   logic             w_stall;
   logic             w_e1_load;
   logic [FW-1:0]    w_fwd_a;
   logic [FW-1:0]    w_fwd_b;

   function automatic logic f_match(input ent_t e, input logic [ADDR_W-1:0] rs, input logic used);
      return e.v && e.we && (e.rd == rs) && (rs != '0) && used;
   endfunction

   // Search oldest to youngest so the youngest producer overwrites; E[STAGES] is covered by write-through.
   always_comb begin
      w_fwd_a = '0;
      w_fwd_b = '0;
      w_hz    = 1'b0;
      for (int k = STAGES - 1; k >= 1; k--) begin
         if (f_match(r_e[k], id_rs1, id_rs1_used)) w_fwd_a = FW'(k);
         if (f_match(r_e[k], id_rs2, id_rs2_used)) w_fwd_b = FW'(k);
      end
      for (int k = 1; k <= LOAD_GAP; k++) begin
         if (r_e[k].ld && (f_match(r_e[k], id_rs1, id_rs1_used) ||
                           f_match(r_e[k], id_rs2, id_rs2_used)))
            w_hz = 1'b1;
      end
   end

   assign w_kill    = (r_fc != 3'd0);
   assign w_stall   = id_valid & ~w_kill & ~br_taken & w_hz;
   assign w_e1_load = id_valid & ~w_stall & ~w_kill & ~br_taken;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 1; k <= STAGES; k++) r_e[k] <= '0;
         r_fc    <= 3'd0;
         r_fwd_a <= '0;
         r_fwd_b <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_e1_load) r_e[1] <= '{v: 1'b1, rd: id_rd, we: id_we, ld: id_is_load};
         else           r_e[1] <= '0;
         for (int k = 2; k <= STAGES; k++) r_e[k] <= r_e[k-1];

         if (br_taken)    r_fc <= 3'(FLUSH_DEPTH);
         else if (w_kill) r_fc <= r_fc - 3'd1;

         // A bubble entering X must never select a bypass path.
         r_fwd_a <= w_e1_load ? w_fwd_a : '0;
         r_fwd_b <= w_e1_load ? w_fwd_b : '0;

         if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign stall       = w_stall;
   assign kill_id     = w_kill;
   assign fwd_a       = r_fwd_a;
   assign fwd_b       = r_fwd_b;
   assign stall_count = r_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
`timescale 1ns/1ps
// Directed bench: instance A uses default parameters, instance B uses STAGES=4, LOAD_GAP=2, FLUSH_DEPTH=2, CNT_W=4.
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_rs1_used, id_rs2_used, id_we, id_is_load, br_taken;

   logic        a_stall, a_kill;
   logic [0:0]  a_fwd_a, a_fwd_b;
   logic [15:0] a_cnt;
   logic        b_stall, b_kill;
   logic [1:0]  b_fwd_a, b_fwd_b;
   logic [3:0]  b_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_unit u_a (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .br_taken(br_taken),
      .stall(a_stall), .kill_id(a_kill), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .stall_count(a_cnt)
   );

   hazard_unit #(.STAGES(4), .LOAD_GAP(2), .FLUSH_DEPTH(2), .CNT_W(4)) u_b (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .br_taken(br_taken),
      .stall(b_stall), .kill_id(b_kill), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .stall_count(b_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic we, input logic ld, input logic br);
      id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
      id_rd = rd; id_we = we; id_is_load = ld; br_taken = br;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();

      // Reset state
      check("a_rst_stall", a_stall, 0);
      check("a_rst_kill",  a_kill,  0);
      check("a_rst_fwda",  a_fwd_a, 0);
      check("a_rst_fwdb",  a_fwd_b, 0);
      check("a_rst_cnt",   a_cnt,   0);
      check("b_rst_cnt",   b_cnt,   0);

      // ALU-ALU forward, then write-through for the third reader
      drv(1, 1, 1, 2, 1, 5, 1, 0, 0);              // add x5,x1,x2
      check("a_add_stall", a_stall, 0);
      tick();
      drv(1, 5, 1, 3, 1, 6, 1, 0, 0);              // sub x6,x5,x3
      check("a_sub_stall", a_stall, 0);
      tick();
      check("a_sub_fwda", a_fwd_a, 1);
      check("a_sub_fwdb", a_fwd_b, 0);
      drv(1, 5, 1, 5, 1, 7, 1, 0, 0);              // or x7,x5,x5
      tick();
      check("a_wt_fwda", a_fwd_a, 0);
      check("a_wt_fwdb", a_fwd_b, 0);

      // Load-use: one stall cycle, then no forward (load retiring via write-through)
      drv(1, 1, 1, 0, 0, 6, 1, 1, 0);              // lw x6,0(x1)
      check("a_lw_stall", a_stall, 0);
      tick();
      drv(1, 6, 1, 6, 1, 7, 1, 0, 0);              // add x7,x6,x6
      check("a_lu_stall1", a_stall, 1);
      tick();
      check("a_lu_bub_fwda", a_fwd_a, 0);
      check("a_lu_stall2", a_stall, 0);
      check("a_lu_cnt1", a_cnt, 1);
      tick();
      check("a_lu_fwda", a_fwd_a, 0);
      check("a_lu_fwdb", a_fwd_b, 0);
      check("a_lu_cnt2", a_cnt, 1);

      // x0 never matches; unused source and non-writing producer never forward
      drv(1, 1, 1, 0, 0, 0, 1, 0, 0);              // addi x0,x1,4
      tick();
      drv(1, 0, 1, 0, 1, 8, 1, 0, 0);
      check("a_x0_stall", a_stall, 0);
      tick();
      check("a_x0_fwda", a_fwd_a, 0);
      check("a_x0_fwdb", a_fwd_b, 0);
      drv(1, 1, 1, 2, 1, 10, 1, 0, 0);
      tick();
      drv(1, 10, 0, 10, 1, 11, 1, 0, 0);
      tick();
      check("a_unused_fwda", a_fwd_a, 0);
      check("a_used_fwdb",   a_fwd_b, 1);
      drv(1, 1, 1, 2, 1, 12, 0, 0, 0);
      tick();
      drv(1, 12, 1, 0, 0, 13, 1, 0, 0);
      tick();
      check("a_nowe_fwda", a_fwd_a, 0);

      // FLUSH_DEPTH=1 squash window
      drv(1, 1, 1, 0, 0, 14, 1, 0, 1);
      tick();
      check("a_kill_on", a_kill, 1);
      drv(1, 1, 1, 0, 0, 14, 1, 0, 0);
      tick();
      check("a_kill_off", a_kill, 0);

      // Instance B: branch while load-use stall is pending
      do_reset();
      drv(1, 1, 1, 0, 0, 6, 1, 1, 0);              // lw x6
      tick();
      drv(1, 6, 1, 6, 1, 7, 1, 0, 1);              // add x7 + branch taken
      check("b_br_stall", b_stall, 0);
      check("b_br_kill0", b_kill, 0);
      tick();
      drv(1, 6, 1, 6, 1, 7, 1, 0, 0);
      check("b_kill_c1", b_kill, 1);
      check("b_kill_nostall", b_stall, 0);
      tick();
      check("b_kill_c2", b_kill, 1);
      drv(1, 6, 1, 6, 1, 7, 1, 0, 1);              // second branch extends window
      tick();
      drv(1, 6, 1, 6, 1, 7, 1, 0, 0);
      check("b_kill_ext1", b_kill, 1);
      tick();
      check("b_kill_ext2", b_kill, 1);
      tick();
      check("b_kill_end", b_kill, 0);
      check("b_kill_cnt", b_cnt, 0);
      drv(1, 7, 1, 0, 0, 8, 1, 0, 0);              // killed add x7 must not forward
      tick();
      check("b_dropped_fwd", b_fwd_a, 0);

      // Youngest producer wins, then older distances
      drv(1, 1, 1, 0, 0, 9, 1, 0, 0);
      tick();
      drv(1, 1, 1, 0, 0, 12, 1, 0, 0);
      tick();
      drv(1, 2, 1, 0, 0, 9, 1, 0, 0);
      tick();
      drv(1, 9, 1, 3, 1, 13, 1, 0, 0);
      check("b_yng_stall", b_stall, 0);
      tick();
      check("b_yng_fwda", b_fwd_a, 1);
      check("b_yng_fwdb", b_fwd_b, 0);
      drv(1, 9, 0, 9, 1, 14, 1, 0, 0);
      tick();
      check("b_d2_fwda", b_fwd_a, 0);
      check("b_d2_fwdb", b_fwd_b, 2);
      drv(1, 9, 1, 0, 0, 15, 1, 0, 0);
      tick();
      check("b_d3_fwda", b_fwd_a, 3);
      drv(1, 9, 1, 0, 0, 16, 1, 0, 0);
      tick();
      check("b_last_fwda", b_fwd_a, 0);

      // Load at E[2]: one stall cycle; forwarded from S4 afterwards
      drv(1, 1, 1, 0, 0, 9, 1, 1, 0);
      tick();
      drv(1, 1, 1, 0, 0, 16, 1, 0, 0);
      check("b_fill_stall", b_stall, 0);
      tick();
      drv(1, 9, 1, 0, 0, 17, 1, 0, 0);
      check("b_e2_stall1", b_stall, 1);
      tick();
      check("b_e2_stall2", b_stall, 0);
      check("b_e2_cnt", b_cnt, 1);
      tick();
      check("b_e2_fwda", b_fwd_a, 3);

      // Load at E[1]: two stall cycles
      drv(1, 1, 1, 0, 0, 20, 1, 1, 0);
      tick();
      drv(1, 20, 1, 0, 0, 21, 1, 0, 0);
      check("b_e1_stall1", b_stall, 1);
      tick();
      check("b_e1_stall2", b_stall, 1);
      tick();
      check("b_e1_stall3", b_stall, 0);
      check("b_e1_cnt", b_cnt, 3);
      tick();
      check("b_e1_fwda", b_fwd_a, 3);

      // Reset mid-sequence discards tracked producers
      drv(1, 1, 1, 0, 0, 22, 1, 1, 0);
      tick();
      drv(1, 22, 1, 22, 1, 23, 1, 0, 0);
      check("b_pre_rst_stall", b_stall, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check("b_rst_stall", b_stall, 0);
      check("b_rst_fwda",  b_fwd_a, 0);
      check("b_rst_cnt",   b_cnt,   0);
      tick();
      check("b_post_rst_fwda", b_fwd_a, 0);
      check("b_post_rst_fwdb", b_fwd_b, 0);

      // Saturation: self-dependent load chain, 2 stalls per 3 cycles
      do_reset();
      drv(1, 25, 1, 0, 0, 25, 1, 1, 0);
      for (int i = 0; i < 7; i++) tick();
      check("b_sat_mid", b_cnt, 4);
      for (int i = 0; i < 23; i++) tick();
      check("b_sat_full", b_cnt, 4'hF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
